// File: rtl/pipe_pkg.sv
// Shared screen geometry and gap defaults for the pipe obstacle logic.
package pipe_pkg;
  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H      = 480;
  localparam int BIRD_SIZE_DEF = 15;
  localparam int Y_MID         = SCREEN_H / 2;
  // Gap half-height is BIRD_SIZE * (rnd[9:8] + GAP_UNITS_MIN).
  localparam int GAP_UNITS_MIN = 2;

  typedef logic [10:0] coord_t;
endpackage

// File: rtl/scroll_tick.sv
// Scroll strobe generator: one-cycle tick every TICK_DIV enabled clocks.
module scroll_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc   = (r_cnt == TC);
  assign o_tick = i_en & w_tc;

  // Count holds while disabled so a resume finishes the interrupted period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_cnt <= '0;
    else if (i_en) r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
  end
endmodule

// File: rtl/pipe_field.sv
// Multi-slot scrolling pipe generator: move/retire/score per slot, spawn at fixed spacing.
module pipe_field #(
  parameter int N_PIPES    = 3,
  parameter int XW         = 11,
  parameter int SCREEN_W   = pipe_pkg::SCREEN_W_DEF,
  parameter int PIPE_WIDTH = 32,
  parameter int BIRD_X     = 160,
  parameter int BIRD_SIZE  = pipe_pkg::BIRD_SIZE_DEF,
  parameter int CENTER_MIN = 112,
  parameter int SPACING    = 224,
  parameter int TICK_DIV   = 4194304
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            speed,
  input  logic [9:0]            rnd,
  output logic [N_PIPES*XW-1:0] x,
  output logic [N_PIPES*XW-1:0] y0,
  output logic [N_PIPES*XW-1:0] y1,
  output logic [N_PIPES-1:0]    active,
  output logic                  score_pulse,
  output logic                  tick
);
  import pipe_pkg::*;

  localparam logic [XW-1:0] X_SPAWN   = XW'(SCREEN_W);
  localparam logic [XW-1:0] Y0_RST    = XW'(Y_MID + BIRD_SIZE);
  localparam logic [XW-1:0] Y1_RST    = XW'(Y_MID - BIRD_SIZE);
  localparam logic [XW-1:0] SPACING_X = XW'(SPACING);
  localparam logic [XW:0]   BIRD_X_W  = (XW+1)'(BIRD_X);
  localparam logic [XW:0]   PW_W      = (XW+1)'(PIPE_WIDTH);

  logic                w_tick;
  logic [XW-1:0]       w_step;
  logic [N_PIPES-1:0]  w_active;
  logic [N_PIPES-1:0]  w_score;
  logic [N_PIPES-1:0]  w_free_oh;
  logic                w_any_free;
  logic [XW-1:0]       w_dist_sum;
  logic [XW-1:0]       w_dist_next;
  logic                w_spawn;
  logic [XW-1:0]       w_c;
  logic [XW-1:0]       w_h;
  logic [XW-1:0]       r_dist;
  logic                r_score;

  scroll_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .i_en   (start),
    .o_tick (w_tick)
  );

  assign w_step = XW'(speed) + XW'(1);
  assign w_c    = XW'(CENTER_MIN) + XW'(rnd[7:0]);
  assign w_h    = XW'(BIRD_SIZE) * (XW'(rnd[9:8]) + XW'(GAP_UNITS_MIN));

  // Lowest-index free slot, judged on occupancy before this tick.
  always_comb begin
    w_free_oh = '0;
    for (int i = N_PIPES - 1; i >= 0; i--) begin
      if (!w_active[i]) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  assign w_any_free  = |(~w_active);
  assign w_dist_sum  = r_dist + w_step;
  assign w_dist_next = (w_dist_sum >= SPACING_X) ? SPACING_X : w_dist_sum;
  assign w_spawn     = w_tick && w_any_free && (w_dist_next >= SPACING_X);

  for (genvar i = 0; i < N_PIPES; i++) begin : g_slot
    logic [XW-1:0] r_x, r_y0, r_y1;
    logic          r_act;
    logic [XW-1:0] w_x_mv;
    logic          w_retire;
    logic [XW:0]   w_old_tr, w_new_tr;

    assign w_x_mv   = r_x - w_step;
    assign w_retire = r_act && (r_x < w_step);
    assign w_old_tr = {1'b0, r_x} + PW_W;
    assign w_new_tr = {1'b0, w_x_mv} + PW_W;
    assign w_score[i] = r_act && !w_retire && (w_old_tr > BIRD_X_W) && (w_new_tr <= BIRD_X_W);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_act <= 1'b0;
        r_x   <= X_SPAWN;
        r_y0  <= Y0_RST;
        r_y1  <= Y1_RST;
      end else if (w_tick) begin
        if (w_spawn && w_free_oh[i]) begin
          r_act <= 1'b1;
          r_x   <= X_SPAWN;
          r_y0  <= w_c + w_h;
          r_y1  <= w_c - w_h;
        end else if (w_retire) begin
          r_act <= 1'b0;
          r_x   <= X_SPAWN;
        end else if (r_act) begin
          r_x   <= w_x_mv;
        end
      end
    end

    assign w_active[i]     = r_act;
    assign x[i*XW +: XW]   = r_x;
    assign y0[i*XW +: XW]  = r_y0;
    assign y1[i*XW +: XW]  = r_y1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dist  <= SPACING_X;
      r_score <= 1'b0;
    end else begin
      r_score <= w_tick && (|w_score);
      if (w_tick) r_dist <= w_spawn ? '0 : w_dist_next;
    end
  end

  assign active      = w_active;
  assign score_pulse = r_score;
  assign tick        = w_tick;
endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field: spawn, freeze, scoring, retire, reset, speed and full-slot deferral.
module tb_pipe_field;
  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic        start2  = 1'b0;
  logic [1:0]  speed   = 2'd0;
  logic [9:0]  rnd     = 10'd0;
  logic [32:0] x, y0, y1, x2, y02, y12;
  logic [2:0]  active, active2;
  logic        score_pulse, tick, score2, tick2;
  int          n_cmp = 0, n_bad = 0, n_score = 0, n_score2 = 0;

  always #5 clk = ~clk;

  pipe_field #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .speed(speed), .rnd(rnd),
    .x(x), .y0(y0), .y1(y1), .active(active), .score_pulse(score_pulse), .tick(tick)
  );

  pipe_field #(.SPACING(100), .TICK_DIV(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .speed(speed), .rnd(rnd),
    .x(x2), .y0(y02), .y1(y12), .active(active2), .score_pulse(score2), .tick(tick2)
  );

  function automatic logic [10:0] sl(input logic [32:0] v, input int i);
    return v[i*11 +: 11];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (score_pulse) n_score++;
    if (score2) n_score2++;
  endtask

  // Returns one cycle after the tick so the registered update is visible.
  task automatic wait_tick(input bit sel, input string tag, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      cyc();
      n++;
      seen = sel ? tick2 : tick;
    end
    if (!seen) chk({tag, "_timeout"}, 64'(seen), 1);
    cyc();
  endtask

  initial begin
    int n, k, x0_at_s1, frz_ticks;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_active", active, 0);
    chk("rst_x", x, {3{11'd640}});
    chk("rst_y0", y0, {3{11'd255}});
    chk("rst_y1", y1, {3{11'd225}});
    chk("rst_score", score_pulse, 0);

    @(negedge clk);
    reset_n = 1'b1; start = 1'b1; speed = 2'd0; rnd = 10'h310;
    wait_tick(0, "first", n);
    chk("first_latency", n, 3);
    chk("first_active", active, 3'b001);
    chk("first_x0", sl(x, 0), 640);
    chk("first_y0", sl(y0, 0), 203);
    chk("first_y1", sl(y1, 0), 53);
    wait_tick(0, "second", n);
    chk("second_x0", sl(x, 0), 639);

    cyc();
    start = 1'b0;
    frz_ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (tick !== 1'b0) frz_ticks++;
    end
    chk("freeze_tick", frz_ticks, 0);
    chk("freeze_x0", sl(x, 0), 639);
    start = 1'b1;
    wait_tick(0, "resume", n);
    chk("resume_latency", n, 2);
    chk("resume_x0", sl(x, 0), 638);

    x0_at_s1 = 0;
    k = 0;
    while (sl(x, 0) != 11'd129 && k < 600) begin
      wait_tick(0, "run", n);
      k++;
      if (x0_at_s1 == 0 && active[1]) x0_at_s1 = sl(x, 0);
    end
    chk("run_x0_129", sl(x, 0), 129);
    chk("slot1_spawn_x0", x0_at_s1, 416);
    chk("no_score_early", n_score, 0);
    wait_tick(0, "cross", n);
    chk("cross_x0", sl(x, 0), 128);
    chk("cross_pulse", score_pulse, 1);
    cyc();
    chk("pulse_width", score_pulse, 0);
    k = 0;
    while (sl(x, 0) != 11'd0 && k < 200) begin
      wait_tick(0, "run0", n);
      k++;
    end
    chk("run_x0_0", sl(x, 0), 0);
    chk("score_once", n_score, 1);
    wait_tick(0, "retire", n);
    chk("retire_active", active, 3'b110);
    chk("retire_x0", sl(x, 0), 640);

    #2 reset_n = 1'b0;
    #1;
    chk("midrst_active", active, 0);
    chk("midrst_x", x, {3{11'd640}});
    chk("midrst_y0", y0, {3{11'd255}});
    chk("midrst_y1", y1, {3{11'd225}});
    chk("midrst_score", score_pulse, 0);
    chk("midrst_tick", tick, 0);

    @(negedge clk);
    reset_n = 1'b1; speed = 2'd3; rnd = 10'h0FF;
    wait_tick(0, "spd_first", n);
    chk("spd_active", active, 3'b001);
    chk("spd_y0", sl(y0, 0), 397);
    chk("spd_y1", sl(y1, 0), 337);
    rnd = 10'h200;
    wait_tick(0, "spd_move", n);
    chk("spd_x0_step4", sl(x, 0), 636);
    k = 1;
    while (!active[1] && k < 80) begin
      wait_tick(0, "spd_run", n);
      k++;
    end
    chk("spd_spawn_ticks", k, 56);
    chk("spd_spawn_x0", sl(x, 0), 416);
    chk("spd_spawn_x1", sl(x, 1), 640);
    chk("spd_spawn_y0", sl(y0, 1), 172);
    chk("spd_spawn_y1", sl(y1, 1), 52);

    start = 1'b0; start2 = 1'b1;
    wait_tick(1, "full_first", n);
    chk("full_first_active", active2, 3'b001);
    k = 1;
    while (active2[0] && k < 200) begin
      wait_tick(1, "full_run", n);
      k++;
    end
    chk("full_retire_tick", k, 162);
    chk("full_deferred", active2, 3'b110);
    chk("full_retire_x0", sl(x2, 0), 640);
    rnd = 10'h0FF;
    wait_tick(1, "full_respawn", n);
    chk("full_respawn_active", active2, 3'b111);
    chk("full_respawn_x0", sl(x2, 0), 640);
    chk("full_respawn_y0", sl(y02, 0), 397);
    chk("full_respawn_y1", sl(y12, 0), 337);
    chk("full_x1", sl(x2, 1), 92);
    chk("full_scores", n_score2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pipe_field.md
# pipe_field

Multi-pipe obstacle generator for the Flappy Bird game: it manages N_PIPES independent pipe slots that scroll right-to-left at a selectable speed. New pipes spawn at a fixed horizontal spacing, each with a randomised gap position and size. A one-cycle score pulse fires each time a pipe's trailing edge passes the bird column. It sits between the LFSR/random source and the renderer/collision logic, replacing the single-pipe generator.

## Interface
- N_PIPES, 3: number of pipe slots.
- XW, 11: width of x/y coordinates.
- SCREEN_W, 640: spawn x and retire reload value.
- PIPE_WIDTH, 32: pipe width in px; used only for score crossing.
- BIRD_X, 160: bird left column for scoring.
- BIRD_SIZE, 15: gap unit in px.
- CENTER_MIN, 112: minimum gap centre y.
- SPACING, 224: px scrolled between spawns.
- TICK_DIV, 4194304: clocks per scroll tick (sim uses 4).
- clk  in  1: system clock (12.5 MHz).
- reset_n  in  1: asynchronous, active-low reset.
- start  in  1: level; 1 = run, 0 = freeze all state.
- speed  in  2: px per tick = speed+1 (1..4); sampled each tick.
- rnd  in  10: random word, sampled at spawn.
- x  out  N_PIPES*XW: slot i x at [i*XW +: XW].
- y0  out  N_PIPES*XW: lower-pipe top edge (gap bottom), y0 > y1.
- y1  out  N_PIPES*XW: upper-pipe bottom edge (gap top).
- active  out  N_PIPES: slot i on screen.
- score_pulse  out  1: one-cycle pulse per pipe passing bird.
- tick  out  1: one-cycle scroll strobe (debug/sync).

## Operation
- Reset (async, reset_n=0): every slot active=0, x=SCREEN_W, y0=240+BIRD_SIZE, y1=240-BIRD_SIZE. Tick counter=0; spawn distance dist=SPACING; score_pulse=0, tick=0.
- start=0: tick counter, positions and dist hold. tick and score_pulse are 0.
- Tick: counter counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the counter equals TICK_DIV-1 (while start=1).
- On tick, step=speed+1. For each slot active at the start of the tick:
  - x < step: retire. x←SCREEN_W, active←0.
  - Otherwise x←x-step.
- Score: on tick, a slot scores if x_old+PIPE_WIDTH > BIRD_X and x_new+PIPE_WIDTH ≤ BIRD_X. score_pulse=1 next cycle if any slot scores. SPACING ≥ PIPE_WIDTH+4 guarantees at most one per tick.
- Spawn, on the same tick:
  - dist←min(dist+step, SPACING).
  - If the post-update dist ≥ SPACING and a slot was inactive before this tick, spawn into the lowest such index:
    - active←1, x←SCREEN_W.
    - c=CENTER_MIN+rnd[7:0], h=BIRD_SIZE*(rnd[9:8]+2).
    - y0←c+h, y1←c-h.
    - dist←0.
  - A slot retiring this tick is not reused this tick. The spawned slot does not move this tick.
  - No free slot: dist holds at SPACING and spawning retries every tick.
- First spawn: first tick after start rises from reset, because dist resets to SPACING.
- Inactive slots hold their last y values. Consumers must gate on active.

## Timing
- Arithmetic is unsigned XW-bit. Crossing compares use XW+1 bits. Gap ranges with defaults: c 112..367, h 30..75, y1 ≥ 37, y0 ≤ 442.
- x/y/active update on the clock edge ending the tick cycle. New values are visible the cycle after tick=1.
- score_pulse is registered: it asserts the cycle after the scoring tick, for exactly 1 cycle.
- Latency from start=1 to first movement is TICK_DIV cycles.
- start falling mid-tick-count freezes the count. Resume continues from the frozen count, with no extra tick.
- reset_n mid-operation clears everything immediately, independent of clk.

## Structure
- pipe_pkg: SCREEN_W, SCREEN_H(480), default BIRD_SIZE, coordinate typedef coord_t (logic [10:0]), gap helper constants.
- Sub-module scroll_tick: parametrised TICK_DIV counter with enable (start), async active-low reset, one-cycle tick output.
- pipe_field: slot register arrays, generate loop per slot for move/retire/score, priority encoder for free slot, and spawn/dist logic.

## Test plan
- Reset: assert reset_n=0 mid-run. Required: all active=0, x=640, y0=255, y1=225, score_pulse=0 without a clock edge.
- First spawn: TICK_DIV=4, start=1, speed=0, rnd=10'h3_10. Required: after the 1st tick, slot0 active, x=640, y0=128+75=203, y1=128-75=53. After the 2nd tick, x=639.
- Spacing/speed: speed=3. Required: slot0 x decreases by 4 per tick; slot1 spawns on the 56th tick after slot0 (224/4), while slot0 x=416.
- Score and retire: speed=0, run to slot0 x=128. Required: score_pulse exactly once, the cycle after the tick where x goes 129→128. At x=0 the next tick gives active=0, x=640.
- Full slots: SPACING=100 with N_PIPES=3. Required: 4th spawn deferred until a slot retires. Spawn occurs on the tick after retirement, into that slot index.
- Freeze: start=0 for 50 cycles mid-count. Required: x, dist and tick count unchanged; tick=0 throughout. The first tick after resume occurs at the remaining count.
